// File: rtl/calc_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : calc_engine_if
// Description : Bundle of the calc_engine control and SRAM-port signals.
//               The engine connects through the 'slave' modport; the system
//               side (control logic plus SRAM pair) uses 'master'.
//   start_i, op_i, read/write start/end addresses : run request and config
//   busy_o, done_o, trunc_o, ovf_cnt_o             : run status
//   mem_re_o, mem_raddr_o, mem_rdata_i             : SRAM read port
//   mem_we_o, mem_waddr_o, mem_wdata_o             : SRAM write port
// Revision    : 1.0 - initial release
// ============================================================================
interface calc_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic                  start_i;
    logic [1:0]            op_i;
    logic [ADDR_W-1:0]     read_start_addr_i;
    logic [ADDR_W-1:0]     read_end_addr_i;
    logic [ADDR_W-1:0]     write_start_addr_i;
    logic [ADDR_W-1:0]     write_end_addr_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  trunc_o;
    logic [ADDR_W:0]       ovf_cnt_o;
    logic                  mem_re_o;
    logic [ADDR_W-1:0]     mem_raddr_o;
    logic [2*DATA_W-1:0]   mem_rdata_i;
    logic                  mem_we_o;
    logic [ADDR_W-1:0]     mem_waddr_o;
    logic [2*DATA_W-1:0]   mem_wdata_o;

    modport slave (
        input  start_i, op_i, read_start_addr_i, read_end_addr_i,
               write_start_addr_i, write_end_addr_i, mem_rdata_i,
        output busy_o, done_o, trunc_o, ovf_cnt_o,
               mem_re_o, mem_raddr_o, mem_we_o, mem_waddr_o, mem_wdata_o
    );

    modport master (
        output start_i, op_i, read_start_addr_i, read_end_addr_i,
               write_start_addr_i, write_end_addr_i, mem_rdata_i,
        input  busy_o, done_o, trunc_o, ovf_cnt_o,
               mem_re_o, mem_raddr_o, mem_we_o, mem_waddr_o, mem_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/calc_engine.sv
`default_nettype none
// ============================================================================
// Module      : calc_engine
// Description : Self-sequencing two-operand calculator. On start it walks an
//               inclusive read range, fetching one word {b,a} per step,
//               applies add/sub/min/max, packs two results per output word
//               and writes them over an inclusive write range. Reports done,
//               truncation (write range exhausted first) and a saturating
//               count of add-carry / sub-borrow events.
// Ports       : clk_i  - clock, rising edge
//               rst_ni - asynchronous active-low reset
//               bus    - calc_engine_if.slave (control, status, SRAM ports)
// Options     : CALC_ENGINE_SAT_EN - when defined, add clamps to all-ones on
//               carry and sub clamps to zero on borrow; otherwise both wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    calc_engine_if.slave     bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_EXEC = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                state;
    logic [1:0]            op;
    logic [ADDR_W-1:0]     read_end;
    logic [ADDR_W-1:0]     write_end;
    logic [ADDR_W-1:0]     rptr;
    logic [ADDR_W-1:0]     wptr;
    logic                  half;
    logic [2*DATA_W-1:0]   buffer;
    logic [ADDR_W:0]       ovf_cnt;

    logic                  busy;
    logic                  done;
    logic                  trunc;
    logic                  mem_re;
    logic [ADDR_W-1:0]     mem_raddr;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_waddr;
    logic [2*DATA_W-1:0]   mem_wdata;

    // Datapath on the word presented during EXEC
    logic [DATA_W-1:0]     opa;
    logic [DATA_W-1:0]     opb;
    logic [DATA_W:0]       sum;
    logic [DATA_W-1:0]     diff;
    logic                  borrow;
    logic [DATA_W-1:0]     result;
    logic                  ovf_event;
    logic [2*DATA_W-1:0]   exec_buf;
    logic [ADDR_W:0]       ovf_cnt_next;

    always_comb begin
        opa       = bus.mem_rdata_i[DATA_W-1:0];
        opb       = bus.mem_rdata_i[2*DATA_W-1:DATA_W];
        sum       = {1'b0, opa} + {1'b0, opb};
        diff      = opa - opb;
        borrow    = (opa < opb);
        result    = '0;
        ovf_event = 1'b0;
        case (op)
            2'b00: begin
                ovf_event = sum[DATA_W];
`ifdef CALC_ENGINE_SAT_EN
                result    = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
                result    = sum[DATA_W-1:0];
`endif
            end
            2'b01: begin
                ovf_event = borrow;
`ifdef CALC_ENGINE_SAT_EN
                result    = borrow ? {DATA_W{1'b0}} : diff;
`else
                result    = diff;
`endif
            end
            2'b10:   result = borrow ? opa : opb;
            default: result = borrow ? opb : opa;
        endcase
        // Low half is filled first; the high half is always still zero then
        // because the buffer clears after every write.
        exec_buf = half ? {result, buffer[DATA_W-1:0]}
                        : {buffer[2*DATA_W-1:DATA_W], result};
        ovf_cnt_next = (ovf_event && (ovf_cnt != {(ADDR_W+1){1'b1}}))
                     ? ovf_cnt + 1'b1 : ovf_cnt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            op        <= '0;
            read_end  <= '0;
            write_end <= '0;
            rptr      <= '0;
            wptr      <= '0;
            half      <= 1'b0;
            buffer    <= '0;
            ovf_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            trunc     <= 1'b0;
            mem_re    <= 1'b0;
            mem_raddr <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            done   <= 1'b0;
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        op        <= bus.op_i;
                        read_end  <= bus.read_end_addr_i;
                        write_end <= bus.write_end_addr_i;
                        rptr      <= bus.read_start_addr_i;
                        wptr      <= bus.write_start_addr_i;
                        half      <= 1'b0;
                        buffer    <= '0;
                        ovf_cnt   <= '0;
                        trunc     <= 1'b0;
                        busy      <= 1'b1;
                        mem_re    <= 1'b1;
                        mem_raddr <= bus.read_start_addr_i;
                        state     <= S_RD;
                    end
                end
                S_RD:   state <= S_WAIT;
                S_WAIT: state <= S_EXEC;
                S_EXEC: begin
                    ovf_cnt <= ovf_cnt_next;
                    buffer  <= exec_buf;
                    if (half || (rptr == read_end)) begin
                        mem_we    <= 1'b1;
                        mem_waddr <= wptr;
                        mem_wdata <= exec_buf;
                        state     <= S_WR;
                    end else begin
                        half      <= 1'b1;
                        rptr      <= rptr + 1'b1;
                        mem_re    <= 1'b1;
                        mem_raddr <= rptr + 1'b1;
                        state     <= S_RD;
                    end
                end
                S_WR: begin
                    buffer <= '0;
                    half   <= 1'b0;
                    if (rptr == read_end) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (wptr == write_end) begin
                        trunc <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        rptr      <= rptr + 1'b1;
                        wptr      <= wptr + 1'b1;
                        mem_re    <= 1'b1;
                        mem_raddr <= rptr + 1'b1;
                        state     <= S_RD;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_o      = busy;
    assign bus.done_o      = done;
    assign bus.trunc_o     = trunc;
    assign bus.ovf_cnt_o   = ovf_cnt;
    assign bus.mem_re_o    = mem_re;
    assign bus.mem_raddr_o = mem_raddr;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_waddr_o = mem_waddr;
    assign bus.mem_wdata_o = mem_wdata;
endmodule
`default_nettype wire

// File: tb/tb_calc_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_engine
// Description : Self-checking bench for calc_engine. A reference model turns
//               each job into expected read addresses, write words and final
//               status, queued for a free-running monitor to compare against
//               the SRAM ports and done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_engine;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;
`ifdef CALC_ENGINE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    calc_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    calc_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Read-only SRAM model with two cycles of read latency
    logic [2*DATA_W-1:0] mem [0:DEPTH-1];
    logic [2*DATA_W-1:0] rd_stage;
    always @(posedge clk) begin
        if (bus.mem_re_o) rd_stage <= mem[bus.mem_raddr_o];
        bus.mem_rdata_i <= rd_stage;
    end

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b1;

    logic [ADDR_W-1:0]   exp_raddr_q [$];
    logic [ADDR_W-1:0]   exp_waddr_q [$];
    logic [2*DATA_W-1:0] exp_wdata_q [$];
    logic [ADDR_W:0]     exp_ovf_q   [$];
    bit                  exp_trunc_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: got 0x%0h want no activity", name, act);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            if (bus.mem_re_o && bus.mem_we_o) unexpected("port_overlap", {55'd0, bus.mem_raddr_o});
            if (bus.mem_re_o) begin
                if (exp_raddr_q.size() == 0) unexpected("read_addr", {55'd0, bus.mem_raddr_o});
                else check("read_addr", {55'd0, bus.mem_raddr_o}, {55'd0, exp_raddr_q.pop_front()});
            end
            if (bus.mem_we_o) begin
                if (exp_waddr_q.size() == 0) unexpected("write_addr", {55'd0, bus.mem_waddr_o});
                else begin
                    check("write_addr", {55'd0, bus.mem_waddr_o}, {55'd0, exp_waddr_q.pop_front()});
                    check("write_data", bus.mem_wdata_o, exp_wdata_q.pop_front());
                end
            end
            if (bus.done_o) begin
                if (exp_ovf_q.size() == 0) unexpected("done_pulse", 64'd1);
                else begin
                    check("ovf_cnt", {54'd0, bus.ovf_cnt_o}, {54'd0, exp_ovf_q.pop_front()});
                    check("trunc", {63'd0, bus.trunc_o}, {63'd0, exp_trunc_q.pop_front()});
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] calc(input logic [1:0] op, input longint unsigned a,
                                               input longint unsigned b, output bit ovf);
        longint unsigned r;
        ovf = 1'b0;
        case (op)
            2'd0: begin
                r   = a + b;
                ovf = (r >= 64'h1_0000_0000);
                r   = (SAT && ovf) ? 64'hFFFF_FFFF : r % 64'h1_0000_0000;
            end
            2'd1: begin
                ovf = (a < b);
                r   = (SAT && ovf) ? 64'd0 : (a + 64'h1_0000_0000 - b) % 64'h1_0000_0000;
            end
            2'd2:    r = (a < b) ? a : b;
            default: r = (a < b) ? b : a;
        endcase
        return r[DATA_W-1:0];
    endfunction

    // Queues every expectation of one job; returns cycles from first read
    // cycle to the done pulse, and the expected truncation flag.
    task automatic model_job(input logic [1:0] op, input int rs, input int re, input int ws,
                             input int we, output int n_cyc, output bit tr);
        int n, w, proc, nwr, ovf_total;
        logic [DATA_W-1:0] res [$];
        bit o;
        n  = (re - rs + DEPTH) % DEPTH + 1;
        w  = (we - ws + DEPTH) % DEPTH + 1;
        tr = ((n + 1) / 2 > w);
        proc = tr ? 2 * w : n;
        ovf_total = 0;
        for (int i = 0; i < proc; i++) begin
            logic [2*DATA_W-1:0] word;
            word = mem[(rs + i) % DEPTH];
            exp_raddr_q.push_back(ADDR_W'((rs + i) % DEPTH));
            res.push_back(calc(op, longint'(word[DATA_W-1:0]), longint'(word[2*DATA_W-1:DATA_W]), o));
            if (o) ovf_total++;
        end
        nwr = (proc + 1) / 2;
        for (int j = 0; j < nwr; j++) begin
            logic [DATA_W-1:0] hi;
            hi = (2 * j + 1 < proc) ? res[2 * j + 1] : '0;
            exp_waddr_q.push_back(ADDR_W'((ws + j) % DEPTH));
            exp_wdata_q.push_back({hi, res[2 * j]});
        end
        exp_ovf_q.push_back((ovf_total > 1023) ? 10'h3FF : 10'(ovf_total));
        exp_trunc_q.push_back(tr);
        n_cyc = 3 * proc + nwr;
    endtask

    task automatic drive_start(input logic [1:0] op, input logic [8:0] rs, input logic [8:0] re,
                               input logic [8:0] ws, input logic [8:0] we);
        bus.start_i            = 1'b1;
        bus.op_i               = op;
        bus.read_start_addr_i  = rs;
        bus.read_end_addr_i    = re;
        bus.write_start_addr_i = ws;
        bus.write_end_addr_i   = we;
    endtask

    task automatic run_job(input logic [1:0] op, input logic [8:0] rs, input logic [8:0] re,
                           input logic [8:0] ws, input logic [8:0] we,
                           input bit poke_busy, input bit poke_done);
        int n_cyc;
        int cyc;
        bit tr;
        model_job(op, int'(rs), int'(re), int'(ws), int'(we), n_cyc, tr);
        @(negedge clk);
        drive_start(op, rs, re, ws, we);
        @(negedge clk);
        bus.start_i = 1'b0;
        check("busy_after_start", {63'd0, bus.busy_o}, 64'd1);
        cyc = 0;
        while (bus.done_o !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (poke_busy && n_cyc > 8) begin
                if (cyc == 4) drive_start(~op, 9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom));
                else if (cyc == 5) bus.start_i = 1'b0;
            end
        end
        bus.start_i = 1'b0;
        check("done_latency", 64'(cyc), 64'(n_cyc));
        check("busy_in_done", {63'd0, bus.busy_o}, 64'd1);
        if (poke_done) drive_start(op, 9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom));
        @(negedge clk);
        bus.start_i = 1'b0;
        check("done_one_pulse", {63'd0, bus.done_o}, 64'd0);
        check("busy_cleared", {63'd0, bus.busy_o}, 64'd0);
        check("trunc_held", {63'd0, bus.trunc_o}, {63'd0, tr});
        @(negedge clk);
        check("restart_ignored", {63'd0, bus.busy_o}, 64'd0);
        check("reads_drained", 64'(exp_raddr_q.size()), 64'd0);
        check("writes_drained", 64'(exp_waddr_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {bus.busy_o, bus.done_o, bus.trunc_o, bus.mem_re_o, bus.mem_we_o,
                     bus.ovf_cnt_o, bus.mem_raddr_o, bus.mem_waddr_o}, 64'd0);
        check({name, "_wdata"}, bus.mem_wdata_o, 64'd0);
    endtask

    initial begin
        int k;
        logic [8:0] rs, ws;
        bus.start_i = 1'b0;
        drive_start(2'd0, 9'd0, 9'd0, 9'd0, 9'd0);
        bus.start_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;

        // Even run, add
        mem[0] = {32'd2, 32'd1};
        mem[1] = {32'd4, 32'd3};
        mem[2] = {32'd1, 32'hFFFF_FFFF};
        mem[3] = {32'd5, 32'd5};
        run_job(2'd0, 9'd0, 9'd3, 9'd8, 9'd9, 1'b0, 1'b0);

        // Odd count, sub
        mem[0] = {32'd3, 32'd10};
        mem[1] = {32'd5, 32'd2};
        mem[2] = {32'd7, 32'd7};
        run_job(2'd1, 9'd0, 9'd2, 9'd20, 9'd21, 1'b0, 1'b0);

        // Read range wrapping through the top of memory, max; restart in done cycle
        run_job(2'd3, 9'd510, 9'd1, 9'd100, 9'd101, 1'b0, 1'b1);

        // Truncation: six words, one write slot
        run_job(2'd2, 9'd40, 9'd45, 9'd4, 9'd4, 1'b0, 1'b0);

        // Reset in the middle of a write
        chk_en = 1'b0;
        @(negedge clk);
        drive_start(2'd0, 9'd60, 9'd67, 9'd300, 9'd303);
        @(negedge clk);
        bus.start_i = 1'b0;
        k = 0;
        while (bus.mem_we_o !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("reset_reached_wr", {63'd0, bus.mem_we_o}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("reset_we_drop", {63'd0, bus.mem_we_o}, 64'd0);
        check_all_zero("reset_midrun");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        run_job(2'd0, 9'd60, 9'd67, 9'd300, 9'd303, 1'b0, 1'b0);

        // Start pulse while busy
        run_job(2'd0, 9'd120, 9'd129, 9'd200, 9'd204, 1'b1, 1'b0);

        // Randomized jobs, including write-range wrap and truncation
        for (int t = 0; t < 20; t++) begin
            rs = 9'($urandom);
            ws = 9'($urandom);
            run_job(2'($urandom), rs, rs + 9'($urandom_range(0, 11)),
                    ws, ws + 9'($urandom_range(0, 6)),
                    1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
